// File: rtl/rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rom_loader                                                   |
// | Description : Cartridge image write engine from the ioctl download stream  |
// |               into SDRAM/DDR3, with cart metadata capture for pce_top.     |
// |               Define ROM_CHECKSUM_EN to add the csum output.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rom_loader #(
    parameter int         AW         = 24,
    parameter logic [7:0] CODE_INDEX = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [15:0]   ioctl_dout,
    output logic          ioctl_wait,
    input  logic          swap,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic          mem_req,
    input  logic          sd_ack,
    input  logic          dd_ack,
    output logic [7:0]    rom_sz,
    output logic          hdr,
    output logic          sgx,
    output logic          pop,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0]   csum,
`endif
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BUSY   = 2'd2
    } state_t;

    localparam logic [15:0] c_POP_W0 = 16'h4F50;
    localparam logic [15:0] c_POP_W1 = 16'h5550;
    localparam logic [15:0] c_POP_W2 = 16'h4F4C;
    localparam logic [15:0] c_POP_W3 = 16'h5355;

    state_t        r_state, w_state_nx;
    logic          r_cart_dl_q;
    logic          r_wait, w_wait_nx;
    logic          r_req, w_req_nx;
    logic [AW-1:0] r_addr, w_addr_nx;
    logic [15:0]   r_din, w_din_nx;
    logic          r_sgx, w_sgx_nx;
    logic [1:0]    r_populous, w_populous_nx;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]   r_csum, w_csum_nx;
`endif

    logic          w_cart_dl;
    logic          w_commit;
    logic [15:0]   w_rev;
    logic [15:0]   w_wr_data;
    logic [15:0]   w_sig;
    logic          w_sig_valid;
    logic          w_pop_win;

    assign w_cart_dl = ioctl_download && (ioctl_index != CODE_INDEX);
    assign w_commit  = (r_req == sd_ack) && (r_req == dd_ack);

    always_comb begin
        w_rev = '0;
        for (int i = 0; i < 8; i++) begin
            w_rev[i]     = ioctl_dout[7 - i];
            w_rev[8 + i] = ioctl_dout[15 - i];
        end
    end

    assign w_wr_data = swap ? w_rev : ioctl_dout;

    // Populous title string, checked in both the raw and the copier-header image
    always_comb begin
        w_sig       = 16'h0000;
        w_sig_valid = 1'b1;
        case (r_addr[3:0])
            4'h6:    w_sig = c_POP_W0;
            4'h8:    w_sig = c_POP_W1;
            4'hA:    w_sig = c_POP_W2;
            4'hC:    w_sig = c_POP_W3;
            default: w_sig_valid = 1'b0;
        endcase
    end

    assign w_pop_win = (r_addr[23:4] == 20'h1F2) || (r_addr[23:4] == 20'h212);

    always_comb begin
        w_state_nx    = r_state;
        w_wait_nx     = r_wait;
        w_req_nx      = r_req;
        w_addr_nx     = r_addr;
        w_din_nx      = r_din;
        w_sgx_nx      = r_sgx;
        w_populous_nx = r_populous;
`ifdef ROM_CHECKSUM_EN
        w_csum_nx     = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_cart_dl && !r_cart_dl_q) begin
                    w_addr_nx     = '0;
                    w_populous_nx = 2'b11;
                    w_sgx_nx      = (ioctl_index[4:0] == 5'd2);
`ifdef ROM_CHECKSUM_EN
                    w_csum_nx     = 16'h0000;
`endif
                    w_state_nx    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!w_cart_dl) begin
                    w_state_nx = S_IDLE;
                end else if (ioctl_wr) begin
                    w_din_nx   = w_wr_data;
                    w_req_nx   = ~r_req;
                    w_wait_nx  = 1'b1;
                    w_state_nx = S_BUSY;
                    if (w_pop_win && w_sig_valid && (w_wr_data != w_sig)) begin
                        w_populous_nx[r_addr[13]] = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                // Both controllers must have echoed the toggle before the word retires
                if (w_commit) begin
                    w_wait_nx  = 1'b0;
                    w_addr_nx  = r_addr + AW'(2);
`ifdef ROM_CHECKSUM_EN
                    w_csum_nx  = r_csum + r_din;
`endif
                    w_state_nx = w_cart_dl ? S_ACTIVE : S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cart_dl_q <= 1'b0;
            r_wait      <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_din       <= 16'h0000;
            r_sgx       <= 1'b0;
            r_populous  <= 2'b11;
`ifdef ROM_CHECKSUM_EN
            r_csum      <= 16'h0000;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_cart_dl_q <= w_cart_dl;
            r_wait      <= w_wait_nx;
            r_req       <= w_req_nx;
            r_addr      <= w_addr_nx;
            r_din       <= w_din_nx;
            r_sgx       <= w_sgx_nx;
            r_populous  <= w_populous_nx;
`ifdef ROM_CHECKSUM_EN
            r_csum      <= w_csum_nx;
`endif
        end
    end

    assign ioctl_wait = r_wait;
    assign mem_addr   = r_addr;
    assign mem_din    = r_din;
    assign mem_req    = r_req;
    assign sgx        = r_sgx;
    assign hdr        = r_addr[9];
    assign rom_sz     = r_addr[23:16];
    assign pop        = r_populous[r_addr[9]];
    assign busy       = (r_state != S_IDLE) || r_wait;
`ifdef ROM_CHECKSUM_EN
    assign csum       = r_csum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rom_loader                                                |
// | Description : Self-checking bench for rom_loader with a behavioural model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rom_loader;

    localparam int AW = 24;

    logic          clk_sys        = 1'b0;
    logic          reset_n        = 1'b0;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index    = 8'h00;
    logic          ioctl_wr       = 1'b0;
    logic [15:0]   ioctl_dout     = 16'h0000;
    logic          swap           = 1'b0;
    logic          sd_ack;
    logic          dd_ack;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_req;
    logic [7:0]    rom_sz;
    logic          hdr, sgx, pop, busy;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]   csum;
`endif

    int         n_tests   = 0;
    int         n_fail    = 0;
    int         sd_dly    = 3;
    int         dd_dly    = 3;
    int         sd_cnt    = 0;
    int         dd_cnt    = 0;
    int         exp_addr  = 0;
    logic       exp_req   = 1'b0;
    logic [1:0] exp_flags = 2'b11;
    logic       exp_sgx   = 1'b0;
    logic [15:0] exp_csum = 16'h0000;
    bit         stray_en  = 1'b0;

    always #5 clk_sys = ~clk_sys;

    rom_loader #(.AW(AW), .CODE_INDEX(8'hFF)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .swap           (swap),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_req        (mem_req),
        .sd_ack         (sd_ack),
        .dd_ack         (dd_ack),
        .rom_sz         (rom_sz),
        .hdr            (hdr),
        .sgx            (sgx),
        .pop            (pop),
`ifdef ROM_CHECKSUM_EN
        .csum           (csum),
`endif
        .busy           (busy)
    );

    // Memory controller stand-ins: echo the request toggle after a programmable delay
    initial begin
        sd_ack = 1'b0;
        dd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                sd_ack = 1'b0;
                dd_ack = 1'b0;
                sd_cnt = 0;
                dd_cnt = 0;
            end else begin
                if (mem_req !== sd_ack) begin
                    if (sd_cnt >= sd_dly) begin sd_ack = mem_req; sd_cnt = 0; end
                    else sd_cnt++;
                end
                if (mem_req !== dd_ack) begin
                    if (dd_cnt >= dd_dly) begin dd_ack = mem_req; dd_cnt = 0; end
                    else dd_cnt++;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        r = {<<{b}};
        return r;
    endfunction

    function automatic logic [15:0] sig_word(input int off);
        case (off)
            6:       return 16'h4F50;
            8:       return 16'h5550;
            10:      return 16'h4F4C;
            12:      return 16'h5355;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit in_window(input int a);
        return (((a & ~15) == 32'h1F20) || ((a & ~15) == 32'h2120)) && ((a & 15) >= 6) && ((a & 15) <= 12);
    endfunction

    task automatic wr_word(input logic [15:0] w, input bit sw, input bit full);
        logic [15:0] d;
        int n;
        int exp_n;
        d = sw ? {rev8(w[15:8]), rev8(w[7:0])} : w;
        swap       = sw;
        ioctl_dout = w;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        ioctl_dout = 16'($urandom);
        exp_req    = ~exp_req;
        if (in_window(exp_addr) && (d !== sig_word(exp_addr & 15))) exp_flags[(exp_addr >> 13) & 1] = 1'b0;
        check("wr_din", 32'(mem_din), 32'(d));
        check("wr_addr", 32'(mem_addr), exp_addr);
        if (full) begin
            check("wr_req", 32'(mem_req), 32'(exp_req));
            check("wr_wait_hi", 32'(ioctl_wait), 32'd1);
        end
        n = 1;
        while (ioctl_wait === 1'b1 && n < 40) begin
            if (stray_en && n == 2) begin ioctl_wr = 1'b1; ioctl_dout = 16'($urandom); end
            tick();
            ioctl_wr = 1'b0;
            if (ioctl_wait === 1'b1) n++;
        end
        exp_addr = (exp_addr + 2) & ((1 << AW) - 1);
        exp_csum = exp_csum + d;
        check("wr_wait_lo", 32'(ioctl_wait), 32'd0);
        check("wr_addr_inc", 32'(mem_addr), exp_addr);
        if (full) begin
            exp_n = ((sd_dly > dd_dly) ? sd_dly : dd_dly) + 1;
            check("wr_wait_cycles", n, exp_n);
            check("wr_req_held", 32'(mem_req), 32'(exp_req));
        end
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
        exp_addr  = 0;
        exp_flags = 2'b11;
        exp_sgx   = (idx[4:0] == 5'd2);
        exp_csum  = 16'h0000;
        check("start_busy", 32'(busy), 32'd1);
        check("start_addr", 32'(mem_addr), 32'd0);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
        tick();
        check("end_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_meta(input string tag);
        int h;
        h = (exp_addr >> 9) & 1;
        check({tag, "_rom_sz"}, 32'(rom_sz), (exp_addr >> 16) & 255);
        check({tag, "_hdr"}, 32'(hdr), h);
        check({tag, "_sgx"}, 32'(sgx), 32'(exp_sgx));
        check({tag, "_pop"}, 32'(pop), 32'(exp_flags[h]));
`ifdef ROM_CHECKSUM_EN
        check({tag, "_csum"}, 32'(csum), 32'(exp_csum));
`endif
    endtask

    task automatic load_image(input logic [7:0] idx, input int nbytes, input int bad_addr);
        logic [15:0] w;
        start_dl(idx);
        sd_dly = 0;
        dd_dly = 0;
        for (int a = 0; a < nbytes; a += 2) begin
            w = 16'($urandom);
            if (in_window(a)) w = sig_word(a & 15);
            if (a == bad_addr) w = ~w;
            wr_word(w, 1'b0, 1'b0);
        end
        end_dl();
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #2;
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sgx", 32'(sgx), 32'd0);
        check("rst_pop", 32'(pop), 32'd1);
        reset_n = 1'b1;
        tick();

        // Basic three-word load, index 1, acks after 3 cycles
        start_dl(8'h01);
        sd_dly = 3;
        dd_dly = 3;
        wr_word(16'h1234, 1'b0, 1'b1);
        wr_word(16'h5678, 1'b0, 1'b1);
        wr_word(16'h9ABC, 1'b0, 1'b1);
        end_dl();
        check_meta("basic");
        check("basic_addr", 32'(mem_addr), 32'd6);
        check("basic_req", 32'(mem_req), 32'd1);
        check("basic_rom_sz", 32'(rom_sz), 32'd0);

        // Bit reversal within each byte
        start_dl(8'h01);
        wr_word(16'h0180, 1'b1, 1'b1);
        check("swap_din", 32'(mem_din), 32'h8001);
        end_dl();

        // Skewed acknowledges: DDR3 answers long after SDRAM
        start_dl(8'h01);
        sd_dly = 2;
        dd_dly = 9;
        wr_word(16'hA5C3, 1'b0, 1'b1);
        repeat (3) tick();
        check("skew_addr_once", 32'(mem_addr), 32'd2);
        end_dl();

        // Randomized words, swap and ack latencies, with stray strobes during BUSY
        start_dl(8'h01);
        stray_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            sd_dly = $urandom_range(0, 6);
            dd_dly = $urandom_range(0, 6);
            wr_word(16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        stray_en = 1'b0;
        end_dl();
        check_meta("rand");

        // Cheat-code download must be invisible
        ioctl_index    = 8'hFF;
        ioctl_download = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ioctl_dout = 16'($urandom);
            ioctl_wr   = 1'b1;
            tick();
            ioctl_wr   = 1'b0;
            tick();
            check("code_req", 32'(mem_req), 32'(exp_req));
            check("code_wait", 32'(ioctl_wait), 32'd0);
            check("code_busy", 32'(busy), 32'd0);
        end
        check("code_addr", 32'(mem_addr), exp_addr);
        ioctl_download = 1'b0;
        tick();

        // Header image with signature; raw-image window corrupted
        load_image(8'h02, 32'h2200, 32'h1F2A);
        check_meta("img_hdr_ok");
        check("img_hdr_ok_pop", 32'(pop), 32'd1);
        check("img_hdr_ok_sgx", 32'(sgx), 32'd1);
        check("img_hdr_ok_hdr", 32'(hdr), 32'd1);

        load_image(8'h02, 32'h2200, 32'h212A);
        check_meta("img_hdr_bad");
        check("img_hdr_bad_pop", 32'(pop), 32'd0);

        load_image(8'h01, 32'h2000, 32'h1F2A);
        check_meta("img_raw_bad");
        check("img_raw_bad_pop", 32'(pop), 32'd0);
        check("img_raw_bad_sgx", 32'(sgx), 32'd0);

        // Reset pulse while a write is outstanding
        start_dl(8'h02);
        sd_dly = 0;
        dd_dly = 0;
        wr_word(16'h1111, 1'b0, 1'b0);
        sd_dly = 2;
        dd_dly = 9;
        ioctl_dout = 16'h2222;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tick();
        check("pre_rst_wait", 32'(ioctl_wait), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_din", 32'(mem_din), 32'd0);
        check("mid_rst_sgx", 32'(sgx), 32'd0);
        check("mid_rst_pop", 32'(pop), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rom_sz", 32'(rom_sz), 32'd0);
        ioctl_download = 1'b0;
        exp_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Fresh download after reset resumes normal operation
        start_dl(8'h01);
        sd_dly = 1;
        dd_dly = 2;
        wr_word(16'hBEEF, 1'b0, 1'b1);
        end_dl();
        check_meta("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
